// File: rtl/eth_axis_frame_gen.sv
// AXI-stream Ethernet frame source: 14-byte header plus counting payload, programmable count/gap.
// Optional ETH_FRAME_GEN_ERR_INJECT_EN adds err_every_i to mark periodic frames bad via tuser.

module eth_axis_frame_gen #(
   parameter int unsigned MAX_PAYLOAD = 1500,
   parameter int unsigned GAP_CYCLES  = 12,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                 logic_clk,
   input  logic                 logic_rst_n,
   input  logic                 start_i,
   input  logic                 stop_i,
   input  logic [CNT_WIDTH-1:0] frame_count_i,
   input  logic [10:0]          payload_len_i,
   input  logic [47:0]          dst_mac_i,
   input  logic [47:0]          src_mac_i,
   input  logic [15:0]          ethertype_i,
`ifdef ETH_FRAME_GEN_ERR_INJECT_EN
   input  logic [7:0]           err_every_i,
`endif
   output logic [7:0]           tx_axis_tdata,
   output logic                 tx_axis_tvalid,
   input  logic                 tx_axis_tready,
   output logic                 tx_axis_tlast,
   output logic                 tx_axis_tuser,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [CNT_WIDTH-1:0] frames_sent_o
);

   localparam logic [1:0]  StIdle  = 2'd0;
   localparam logic [1:0]  StHdr   = 2'd1;
   localparam logic [1:0]  StPay   = 2'd2;
   localparam logic [1:0]  StGap   = 2'd3;
   localparam logic [10:0] MaxLen  = 11'(MAX_PAYLOAD);
   localparam logic [15:0] GapLast = 16'(GAP_CYCLES - 1);
   localparam bit          HasGap  = (GAP_CYCLES != 0);

   logic [1:0]           state_q, state_d;
   logic [10:0]          byte_cnt_q, byte_cnt_d;
   logic [15:0]          gap_cnt_q, gap_cnt_d;
   logic [CNT_WIDTH-1:0] frames_sent_q, frames_sent_d;
   logic                 stop_q, stop_d;
   logic                 done_q, done_d;
   logic                 load;

   logic [CNT_WIDTH-1:0] cnt_q;
   logic [10:0]          len_q, len_eff;
   logic [111:0]         hdr_q, hdr_shift;

   logic                 hs, last_byte, last_hs, stop_seen, reached_pay, reached_gap;
   logic [CNT_WIDTH-1:0] sent_inc;

   assign hs          = tx_axis_tvalid & tx_axis_tready;
   assign last_byte   = (state_q == StPay) && (byte_cnt_q == len_q - 11'd1);
   assign last_hs     = last_byte & hs;
   assign sent_inc    = (&frames_sent_q) ? frames_sent_q : frames_sent_q + CNT_WIDTH'(1);
   assign stop_seen   = stop_q | stop_i;
   assign reached_pay = (cnt_q != '0) && (sent_inc == cnt_q);
   assign reached_gap = (cnt_q != '0) && (frames_sent_q == cnt_q);

   assign len_eff = (payload_len_i == 11'd0) ? 11'd1 :
                    (payload_len_i > MaxLen) ? MaxLen : payload_len_i;

   always_comb begin
      state_d       = state_q;
      byte_cnt_d    = byte_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      frames_sent_d = frames_sent_q;
      stop_d        = stop_q;
      done_d        = 1'b0;
      load          = 1'b0;
      if (state_q != StIdle) stop_d = stop_q | stop_i;
      case (state_q)
         StIdle: begin
            stop_d = 1'b0;
            if (start_i) begin
               load          = 1'b1;
               state_d       = StHdr;
               byte_cnt_d    = 11'd0;
               frames_sent_d = '0;
            end
         end
         StHdr: begin
            if (hs) begin
               if (byte_cnt_q == 11'd13) begin
                  byte_cnt_d = 11'd0;
                  state_d    = StPay;
               end else begin
                  byte_cnt_d = byte_cnt_q + 11'd1;
               end
            end
         end
         StPay: begin
            if (last_hs) begin
               frames_sent_d = sent_inc;
               byte_cnt_d    = 11'd0;
               gap_cnt_d     = 16'd0;
               if (HasGap) begin
                  state_d = StGap;
               end else if (stop_seen || reached_pay) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  state_d = StHdr;
               end
            end else if (hs) begin
               byte_cnt_d = byte_cnt_q + 11'd1;
            end
         end
         StGap: begin
            if (gap_cnt_q == GapLast) begin
               if (stop_seen || reached_gap) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  state_d = StHdr;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge logic_clk or negedge logic_rst_n) begin
      if (!logic_rst_n) begin
         state_q       <= StIdle;
         byte_cnt_q    <= 11'd0;
         gap_cnt_q     <= 16'd0;
         frames_sent_q <= '0;
         stop_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         byte_cnt_q    <= byte_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         frames_sent_q <= frames_sent_d;
         stop_q        <= stop_d;
         done_q        <= done_d;
      end
   end

   // Config is captured once per start so mid-run input changes cannot corrupt a frame.
   always_ff @(posedge logic_clk or negedge logic_rst_n) begin
      if (!logic_rst_n) begin
         cnt_q <= '0;
         len_q <= 11'd1;
         hdr_q <= '0;
      end else if (load) begin
         cnt_q <= frame_count_i;
         len_q <= len_eff;
         hdr_q <= {dst_mac_i, src_mac_i, ethertype_i};
      end
   end

`ifdef ETH_FRAME_GEN_ERR_INJECT_EN
   logic [7:0] err_every_q, err_cnt_q;
   logic       err_hit;

   // err_cnt_q tracks frame_index mod err_every, avoiding a divider.
   assign err_hit = (err_every_q != 8'd0) && (err_cnt_q == err_every_q - 8'd1);

   always_ff @(posedge logic_clk or negedge logic_rst_n) begin
      if (!logic_rst_n) begin
         err_every_q <= 8'd0;
         err_cnt_q   <= 8'd0;
      end else if (load) begin
         err_every_q <= err_every_i;
         err_cnt_q   <= 8'd0;
      end else if (last_hs) begin
         err_cnt_q <= err_hit ? 8'd0 : err_cnt_q + 8'd1;
      end
   end

   assign tx_axis_tuser = last_byte & err_hit;
`else
   assign tx_axis_tuser = 1'b0;
`endif

   assign hdr_shift = hdr_q << {byte_cnt_q[3:0], 3'b000};

   always_comb begin
      tx_axis_tdata = 8'h00;
      if (state_q == StHdr) tx_axis_tdata = hdr_shift[111:104];
      else if (state_q == StPay) tx_axis_tdata = frames_sent_q[7:0] + byte_cnt_q[7:0];
   end

   assign tx_axis_tvalid = (state_q == StHdr) || (state_q == StPay);
   assign tx_axis_tlast  = last_byte;
   assign busy_o         = (state_q != StIdle);
   assign done_o         = done_q;
   assign frames_sent_o  = frames_sent_q;

endmodule

// File: tb/tb_eth_axis_frame_gen.sv
// Self-checking bench for eth_axis_frame_gen: randomized runs against a frame-list reference model.
// Define ETH_FRAME_GEN_ERR_INJECT_EN to also exercise the tuser error-inject path.

module tb_eth_axis_frame_gen;

   localparam int GAP = 12;
   localparam int CW  = 16;

   logic          logic_clk = 1'b0;
   logic          logic_rst_n = 1'b0;
   logic          start_i = 1'b0;
   logic          stop_i = 1'b0;
   logic [CW-1:0] frame_count_i = '0;
   logic [10:0]   payload_len_i = '0;
   logic [47:0]   dst_mac_i = '0;
   logic [47:0]   src_mac_i = '0;
   logic [15:0]   ethertype_i = '0;
   logic [7:0]    err_every = '0;
   logic          tx_axis_tready = 1'b1;
   logic [7:0]    tx_axis_tdata;
   logic          tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser, busy_o, done_o;
   logic [CW-1:0] frames_sent_o;

   int          vectors = 0;
   int          miscompares = 0;
   bit          rand_ready = 1'b0;
   logic [9:0]  exp_q[$];
   logic [9:0]  cap_q[$];
   int          gap_q[$];
   int          done_cnt = 0;
   int          proto_viol = 0;
   bit          prev_stall = 1'b0;
   bit          prev_busy = 1'b0;
   logic [9:0]  prev_word = '0;
   bit          in_gap = 1'b0;
   int          gap_run = 0;

   eth_axis_frame_gen #(
      .MAX_PAYLOAD(1500),
      .GAP_CYCLES (GAP),
      .CNT_WIDTH  (CW)
   ) dut (
      .logic_clk     (logic_clk),
      .logic_rst_n   (logic_rst_n),
      .start_i       (start_i),
      .stop_i        (stop_i),
      .frame_count_i (frame_count_i),
      .payload_len_i (payload_len_i),
      .dst_mac_i     (dst_mac_i),
      .src_mac_i     (src_mac_i),
      .ethertype_i   (ethertype_i),
`ifdef ETH_FRAME_GEN_ERR_INJECT_EN
      .err_every_i   (err_every),
`endif
      .tx_axis_tdata (tx_axis_tdata),
      .tx_axis_tvalid(tx_axis_tvalid),
      .tx_axis_tready(tx_axis_tready),
      .tx_axis_tlast (tx_axis_tlast),
      .tx_axis_tuser (tx_axis_tuser),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .frames_sent_o (frames_sent_o)
   );

   always #5 logic_clk = ~logic_clk;

   always @(posedge logic_clk) begin
      #1;
      tx_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Stream monitor: captures handshaked bytes, gap lengths, done pulses and protocol violations.
   always @(negedge logic_clk) begin
      if (!logic_rst_n) begin
         prev_stall = 1'b0;
         prev_busy  = 1'b0;
         in_gap     = 1'b0;
      end else begin
         if (prev_stall && (tx_axis_tvalid !== 1'b1 ||
                            {tx_axis_tuser, tx_axis_tlast, tx_axis_tdata} !== prev_word))
            proto_viol++;
         prev_stall = tx_axis_tvalid && !tx_axis_tready;
         prev_word  = {tx_axis_tuser, tx_axis_tlast, tx_axis_tdata};
         if (in_gap) begin
            if (tx_axis_tvalid || !busy_o) begin
               gap_q.push_back(gap_run);
               in_gap = 1'b0;
            end else begin
               gap_run++;
            end
         end
         if (tx_axis_tvalid && tx_axis_tready) begin
            cap_q.push_back({tx_axis_tuser, tx_axis_tlast, tx_axis_tdata});
            if (tx_axis_tlast) begin
               in_gap  = 1'b1;
               gap_run = 0;
            end
         end
         if (done_o !== (prev_busy && !busy_o)) proto_viol++;
         if (done_o === 1'b1) done_cnt++;
         prev_busy = busy_o;
      end
   end

   function automatic int eff_len(int len);
      if (len == 0) return 1;
      if (len > 1500) return 1500;
      return len;
   endfunction

   // Reference: list of frames as header bytes then (frame_index + k) mod 256 payload.
   function automatic void build_exp(int count, int len, logic [47:0] dst, logic [47:0] src,
                                     logic [15:0] et, int ee);
      logic [111:0] hdr;
      int           l;
      hdr = {dst, src, et};
      l   = eff_len(len);
      exp_q.delete();
      for (int f = 0; f < count; f++) begin
         for (int b = 0; b < 14; b++) exp_q.push_back({2'b00, hdr[111-8*b -: 8]});
         for (int k = 0; k < l; k++) begin
            logic lst, usr;
            lst = (k == l - 1);
            usr = lst && (ee != 0) && (((f + 1) % ee) == 0);
            exp_q.push_back({usr, lst, 8'((f + k) % 256)});
         end
      end
   endfunction

   function automatic int first_diff();
      int n;
      n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (cap_q[i] !== exp_q[i]) return i;
      if (cap_q.size() != exp_q.size()) return n;
      return -1;
   endfunction

   task automatic start_run(int count, int len, logic [47:0] dst, logic [47:0] src,
                            logic [15:0] et, bit rr, bit with_stop);
      @(posedge logic_clk);
      #2;
      cap_q.delete();
      gap_q.delete();
      done_cnt      = 0;
      proto_viol    = 0;
      frame_count_i = CW'(count);
      payload_len_i = 11'(len);
      dst_mac_i     = dst;
      src_mac_i     = src;
      ethertype_i   = et;
      rand_ready    = rr;
      stop_i        = with_stop;
      start_i       = 1'b1;
      @(posedge logic_clk);
      #2;
      start_i = 1'b0;
      stop_i  = 1'b0;
   endtask

   task automatic wait_done(int budget, output bit timed_out);
      timed_out = 1'b1;
      for (int c = 0; c < budget; c++) begin
         @(posedge logic_clk);
         if (done_cnt > 0) begin
            timed_out = 1'b0;
            break;
         end
      end
      #2;
      rand_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      vectors++;
      if ({tx_axis_tdata, tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser} !== 11'd0) begin
         miscompares++;
         $display("FAIL reset_axis: got data=%h valid=%b last=%b user=%b want all 0",
                  tx_axis_tdata, tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser);
      end
      vectors++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_status: got busy=%b done=%b want 0 0", busy_o, done_o);
      end
      vectors++;
      if (frames_sent_o !== '0) begin
         miscompares++;
         $display("FAIL reset_frames: got %0d want 0", frames_sent_o);
      end
      #1 logic_rst_n = 1'b1;
      repeat (3) @(posedge logic_clk);
      #2;
      stop_i = 1'b1;
      repeat (3) @(posedge logic_clk);
      #2;
      stop_i = 1'b0;
      vectors++;
      if (busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_stop_ignored: got busy=%b want 0", busy_o);
      end
   endtask

   task automatic test_basic();
      bit to;
      int d;
      build_exp(1, 4, 48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800, int'(err_every));
      start_run(1, 4, 48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800, 1'b0, 1'b0);
      wait_done(400, to);
      vectors++;
      if (to) begin miscompares++; $display("FAIL basic_done: got timeout want done_o"); end
      d = first_diff();
      vectors++;
      if (d != -1) begin
         miscompares++;
         $display("FAIL basic_stream: differ at byte %0d, got %0d bytes want %0d",
                  d, cap_q.size(), exp_q.size());
      end
      vectors++;
      if (gap_q.size() != 1 || gap_q[0] != GAP) begin
         miscompares++;
         $display("FAIL basic_gap: got %0d gaps (first %0d) want 1 gap of %0d",
                  gap_q.size(), (gap_q.size() > 0) ? gap_q[0] : -1, GAP);
      end
      vectors++;
      if (frames_sent_o !== 16'd1 || done_cnt != 1 || proto_viol != 0) begin
         miscompares++;
         $display("FAIL basic_status: got sent=%0d done=%0d viol=%0d want 1 1 0",
                  frames_sent_o, done_cnt, proto_viol);
      end
   endtask

   task automatic test_multi();
      bit          to;
      int          d, bad_gaps;
      logic [47:0] dst, src;
      dst = 48'({$urandom, $urandom});
      src = 48'({$urandom, $urandom});
      build_exp(3, 1, dst, src, 16'h88B5, int'(err_every));
      start_run(3, 1, dst, src, 16'h88B5, 1'b0, 1'b1);
      wait_done(400, to);
      vectors++;
      if (to) begin miscompares++; $display("FAIL multi_done: got timeout want done_o"); end
      d = first_diff();
      vectors++;
      if (d != -1) begin
         miscompares++;
         $display("FAIL multi_stream: differ at byte %0d, got %0d bytes want %0d",
                  d, cap_q.size(), exp_q.size());
      end
      bad_gaps = 0;
      foreach (gap_q[i]) if (gap_q[i] != GAP) bad_gaps++;
      vectors++;
      if (gap_q.size() != 3 || bad_gaps != 0) begin
         miscompares++;
         $display("FAIL multi_gaps: got %0d gaps, %0d wrong want 3 gaps of %0d",
                  gap_q.size(), bad_gaps, GAP);
      end
      vectors++;
      if (frames_sent_o !== 16'd3 || done_cnt != 1 || proto_viol != 0) begin
         miscompares++;
         $display("FAIL multi_status: got sent=%0d done=%0d viol=%0d want 3 1 0",
                  frames_sent_o, done_cnt, proto_viol);
      end
   endtask

   task automatic test_backpressure();
      bit          to;
      int          d, len;
      logic [47:0] dst, src;
      logic [15:0] et;
      len = $urandom_range(1, 40);
      dst = 48'({$urandom, $urandom});
      src = 48'({$urandom, $urandom});
      et  = 16'($urandom);
      build_exp(2, len, dst, src, et, int'(err_every));
      start_run(2, len, dst, src, et, 1'b1, 1'b0);
      repeat (5) @(posedge logic_clk);
      #2;
      payload_len_i = 11'(len + 7);
      dst_mac_i     = ~dst;
      frame_count_i = 16'd9;
      start_i       = 1'b1;
      @(posedge logic_clk);
      #2;
      start_i = 1'b0;
      wait_done(2000, to);
      vectors++;
      if (to) begin miscompares++; $display("FAIL bp_done: got timeout want done_o"); end
      d = first_diff();
      vectors++;
      if (d != -1) begin
         miscompares++;
         $display("FAIL bp_stream: differ at byte %0d, got %0d bytes want %0d",
                  d, cap_q.size(), exp_q.size());
      end
      vectors++;
      if (proto_viol != 0 || frames_sent_o !== 16'd2) begin
         miscompares++;
         $display("FAIL bp_status: got viol=%0d sent=%0d want 0 2", proto_viol, frames_sent_o);
      end
   endtask

   task automatic test_stop();
      bit          to;
      int          d;
      logic [47:0] dst, src;
      dst = 48'({$urandom, $urandom});
      src = 48'({$urandom, $urandom});
      build_exp(2, 60, dst, src, 16'h0800, int'(err_every));
      start_run(0, 60, dst, src, 16'h0800, 1'b0, 1'b0);
      to = 1'b1;
      for (int c = 0; c < 1000; c++) begin
         @(posedge logic_clk);
         if (done_cnt > 0) begin
            to = 1'b0;
            break;
         end
         #2;
         if (cap_q.size() >= 74 + 29) stop_i = 1'b1;
      end
      #2;
      stop_i = 1'b0;
      vectors++;
      if (to) begin miscompares++; $display("FAIL stop_done: got timeout want done_o"); end
      d = first_diff();
      vectors++;
      if (d != -1) begin
         miscompares++;
         $display("FAIL stop_stream: differ at byte %0d, got %0d bytes want %0d",
                  d, cap_q.size(), exp_q.size());
      end
      vectors++;
      if (frames_sent_o !== 16'd2 || done_cnt != 1 || proto_viol != 0) begin
         miscompares++;
         $display("FAIL stop_status: got sent=%0d done=%0d viol=%0d want 2 1 0",
                  frames_sent_o, done_cnt, proto_viol);
      end
   endtask

   task automatic test_len_bounds();
      bit to;
      int d;
      int lens[2] = '{0, 2047};
      foreach (lens[i]) begin
         build_exp(1, lens[i], 48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0806, int'(err_every));
         start_run(1, lens[i], 48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0806, 1'b0, 1'b0);
         wait_done(2000, to);
         vectors++;
         if (to) begin
            miscompares++;
            $display("FAIL len_done: len=%0d got timeout want done_o", lens[i]);
         end
         d = first_diff();
         vectors++;
         if (d != -1) begin
            miscompares++;
            $display("FAIL len_stream: len=%0d differ at byte %0d, got %0d bytes want %0d",
                     lens[i], d, cap_q.size(), exp_q.size());
         end
      end
      vectors++;
      if (cap_q.size() != 1514 || cap_q[1513][8] !== 1'b1) begin
         miscompares++;
         $display("FAIL len_max: got %0d bytes want 1514 with tlast on the last", cap_q.size());
      end
   endtask

   task automatic test_reset_mid();
      bit          to;
      int          d;
      logic [47:0] dst, src;
      dst = 48'({$urandom, $urandom});
      src = 48'({$urandom, $urandom});
      start_run(0, 60, dst, src, 16'h0800, 1'b0, 1'b0);
      to = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(posedge logic_clk);
         if (cap_q.size() >= 74 + 20) begin
            to = 1'b0;
            break;
         end
      end
      vectors++;
      if (to) begin miscompares++; $display("FAIL rstmid_reach: got timeout want frame 2 PAY"); end
      @(negedge logic_clk);
      #2 logic_rst_n = 1'b0;
      #1;
      vectors++;
      if (tx_axis_tvalid !== 1'b0 || busy_o !== 1'b0 || frames_sent_o !== '0 ||
          tx_axis_tlast !== 1'b0) begin
         miscompares++;
         $display("FAIL rstmid_outputs: got valid=%b busy=%b sent=%0d last=%b want 0 0 0 0",
                  tx_axis_tvalid, busy_o, frames_sent_o, tx_axis_tlast);
      end
      @(negedge logic_clk);
      #2 logic_rst_n = 1'b1;
      build_exp(1, 5, src, dst, 16'h86DD, int'(err_every));
      start_run(1, 5, src, dst, 16'h86DD, 1'b0, 1'b0);
      wait_done(400, to);
      d = first_diff();
      vectors++;
      if (to || d != -1) begin
         miscompares++;
         $display("FAIL rstmid_clean: timeout=%b differ at byte %0d, got %0d bytes want %0d",
                  to, d, cap_q.size(), exp_q.size());
      end
      vectors++;
      if (frames_sent_o !== 16'd1) begin
         miscompares++;
         $display("FAIL rstmid_frames: got %0d want 1", frames_sent_o);
      end
   endtask

   task automatic test_random();
      bit          to, rr;
      int          d, cnt, len;
      logic [47:0] dst, src;
      logic [15:0] et;
      for (int it = 0; it < 6; it++) begin
         cnt = $urandom_range(1, 5);
         len = $urandom_range(0, 50);
         rr  = 1'($urandom_range(0, 1));
         dst = 48'({$urandom, $urandom});
         src = 48'({$urandom, $urandom});
         et  = 16'($urandom);
`ifdef ETH_FRAME_GEN_ERR_INJECT_EN
         err_every = (it == 0) ? 8'd2 : 8'($urandom_range(0, 3));
`endif
         build_exp(cnt, len, dst, src, et, int'(err_every));
         start_run(cnt, len, dst, src, et, rr, 1'b0);
         wait_done(cnt * (14 + eff_len(len) + GAP) * 6 + 200, to);
         d = first_diff();
         vectors++;
         if (to || d != -1) begin
            miscompares++;
            $display("FAIL rand_stream: it=%0d timeout=%b differ at byte %0d, got %0d want %0d",
                     it, to, d, cap_q.size(), exp_q.size());
         end
         vectors++;
         if (frames_sent_o !== CW'(cnt) || proto_viol != 0) begin
            miscompares++;
            $display("FAIL rand_status: it=%0d got sent=%0d viol=%0d want %0d 0",
                     it, frames_sent_o, proto_viol, cnt);
         end
      end
      err_every = '0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_multi();
      test_backpressure();
      test_stop();
      test_len_bounds();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
